// File: rtl/ascon_perm_ti_ctrl.sv
// Round scheduler for the three-share TI Ascon permutation: holds the shares,
// applies round constants to share 0 and alternates masked S-box / linear layer.

module sub_layer_ti_core #(
    parameter bit INV_X2 = 1'b0
) (
    input  logic [319:0] a_in,
    input  logic [319:0] b_in,
    output logic [319:0] y
);
    // Output share i is built only from shares i+1 (a) and i+2 (b).
    function automatic logic [63:0] chi_lane(input logic [63:0] pi, input logic [63:0] p1,
                                             input logic [63:0] p2, input logic [63:0] q1,
                                             input logic [63:0] q2);
        return pi ^ p2 ^ (p1 & p2) ^ (p1 & q2) ^ (q1 & p2);
    endfunction

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] p0, p1, p2, p3, p4;
    logic [63:0] q0, q1, q2, q3, q4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        {a0, a1, a2, a3, a4} = a_in;
        {b0, b1, b2, b3, b4} = b_in;
        p0 = a0 ^ a4;
        p1 = a1;
        p2 = a2 ^ a1;
        p3 = a3;
        p4 = a4 ^ a3;
        q0 = b0 ^ b4;
        q1 = b1;
        q2 = b2 ^ b1;
        q3 = b3;
        q4 = b4 ^ b3;
        c0 = chi_lane(p0, p1, p2, q1, q2);
        c1 = chi_lane(p1, p2, p3, q2, q3);
        c2 = chi_lane(p2, p3, p4, q3, q4);
        c3 = chi_lane(p3, p4, p0, q4, q0);
        c4 = chi_lane(p4, p0, p1, q0, q1);
        c1 = c1 ^ c0;
        c0 = c0 ^ c4;
        c3 = c3 ^ c2;
        if (INV_X2) begin
            c2 = ~c2;
        end
        y = {c0, c1, c2, c3, c4};
    end
endmodule

module sub_layer_ti_0 (
    input  logic [319:0] a_in,
    input  logic [319:0] b_in,
    output logic [319:0] y
);
    sub_layer_ti_core #(.INV_X2(1'b1)) u_core (.a_in(a_in), .b_in(b_in), .y(y));
endmodule

module sub_layer_ti_1 (
    input  logic [319:0] a_in,
    input  logic [319:0] b_in,
    output logic [319:0] y
);
    sub_layer_ti_core #(.INV_X2(1'b0)) u_core (.a_in(a_in), .b_in(b_in), .y(y));
endmodule

module sub_layer_ti_2 (
    input  logic [319:0] a_in,
    input  logic [319:0] b_in,
    output logic [319:0] y
);
    sub_layer_ti_core #(.INV_X2(1'b0)) u_core (.a_in(a_in), .b_in(b_in), .y(y));
endmodule

module ascon_perm_ti_ctrl #(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sel_pb,
    input  logic [319:0] s0_in,
    input  logic [319:0] s1_in,
    input  logic [319:0] s2_in,
    output logic [319:0] s0_out,
    output logic [319:0] s1_out,
    output logic [319:0] s2_out,
    output logic         busy,
    output logic         done,
    output logic [3:0]   round_idx
);
    typedef enum logic [1:0] {IDLE, SBOX, LIN} state_t;

    localparam logic [3:0] PA_START = 4'(12 - PA_ROUNDS);
    localparam logic [3:0] PB_START = 4'(12 - PB_ROUNDS);

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] lin_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   round_idx_q, round_idx_d;
    logic [319:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic         done_q, done_d;

    logic [7:0]   rc_w;
    logic [319:0] s0_cadd;
    logic [319:0] y0_w, y1_w, y2_w;

    // Round constant lands in the low byte of lane x2, share 0 only.
    assign rc_w    = {4'hF - round_idx_q, round_idx_q};
    assign s0_cadd = s0_q ^ {184'd0, rc_w, 128'd0};

    sub_layer_ti_0 u_sub0 (.a_in(s1_q),    .b_in(s2_q),    .y(y0_w));
    sub_layer_ti_1 u_sub1 (.a_in(s2_q),    .b_in(s0_cadd), .y(y1_w));
    sub_layer_ti_2 u_sub2 (.a_in(s0_cadd), .b_in(s1_q),    .y(y2_w));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_idx_q <= 4'd0;
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s0_d        = s0_in;
                    s1_d        = s1_in;
                    s2_d        = s2_in;
                    round_idx_d = sel_pb ? PB_START : PA_START;
                    state_d     = SBOX;
                end
            end
            SBOX: begin
                s0_d    = y0_w;
                s1_d    = y1_w;
                s2_d    = y2_w;
                state_d = LIN;
            end
            LIN: begin
                s0_d = lin_layer(s0_q);
                s1_d = lin_layer(s1_q);
                s2_d = lin_layer(s2_q);
                if (round_idx_q == 4'd11) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    round_idx_d = round_idx_q + 4'd1;
                    state_d     = SBOX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s0_out    = s0_q;
    assign s1_out    = s1_q;
    assign s2_out    = s2_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign round_idx = round_idx_q;
endmodule

// File: tb/tb_ascon_perm_ti_ctrl.sv
// Directed bench for ascon_perm_ti_ctrl against an unmasked Ascon reference.
module tb_ascon_perm_ti_ctrl;
    logic         clk = 1'b0;
    logic         rst_n, start, sel_pb;
    logic [319:0] s0_in, s1_in, s2_in;
    logic [319:0] s0_out, s1_out, s2_out;
    logic         busy, done;
    logic [3:0]   round_idx;

    int checks = 0;
    int errors = 0;
    logic [319:0] um0, um1, um2, um_state;

    ascon_perm_ti_ctrl #(.PA_ROUNDS(12), .PB_ROUNDS(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_pb(sel_pb),
        .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in),
        .s0_out(s0_out), .s1_out(s1_out), .s2_out(s2_out),
        .busy(busy), .done(done), .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_ref(input logic [319:0] s, input int rounds);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        int c;
        {x0, x1, x2, x3, x4} = s;
        for (int r = 12 - rounds; r < 12; r++) begin
            c  = ((15 - r) << 4) | r;
            x2 = x2 ^ {56'd0, 8'(c)};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
            x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
            x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
            x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
            x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drives start for one edge; returns #1 after the load edge.
    task automatic launch(input logic [319:0] a, input logic [319:0] b,
                          input logic [319:0] c, input logic pb);
        start = 1'b1; sel_pb = pb; s0_in = a; s1_in = b; s2_in = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = busy;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        if (lat < 0) $display("FAIL wait_done timeout after %0d cycles", budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel_pb = 1'b0; s0_in = '0; s1_in = '0; s2_in = '0;
        #1;
        checks++; if ({s0_out, s1_out, s2_out} !== 960'd0) begin errors++; $display("FAIL reset_shares got nonzero want 0"); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
        checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", round_idx); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || s0_out !== 320'd0) begin errors++; $display("FAIL idle_no_start busy=%b s0=%h", busy, s0_out); end
    endtask

    task automatic test_pa_unmasked();
        int lat; bit bok; logic [319:0] exp_r;
        um_state = rand320();
        exp_r = ascon_ref(um_state, 12);
        launch(um_state, '0, '0, 1'b0);
        checks++; if (s0_out !== um_state) begin errors++; $display("FAIL load_s0 got %h want %h", s0_out, um_state); end
        wait_done(60, lat, bok);
        checks++; if (lat !== 24) begin errors++; $display("FAIL pa_latency got %0d want 24", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL pa_busy got %b want 1 during run", bok); end
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== exp_r) begin errors++; $display("FAIL pa_result got %h want %h", s0_out ^ s1_out ^ s2_out, exp_r); end
        um0 = s0_out; um1 = s1_out; um2 = s2_out;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
        repeat (4) @(posedge clk); #1;
        checks++; if ({s0_out, s1_out, s2_out} !== {um0, um1, um2}) begin errors++; $display("FAIL idle_hold shares changed"); end
    endtask

    task automatic test_masked();
        int lat; bit bok; logic [319:0] m1, m2, exp_r;
        exp_r = ascon_ref(um_state, 12);
        for (int t = 0; t < 1000; t++) begin
            m1 = rand320(); m2 = rand320();
            launch(um_state ^ m1 ^ m2, m1, m2, 1'b0);
            wait_done(60, lat, bok);
            checks++;
            if (lat !== 24 || (s0_out ^ s1_out ^ s2_out) !== exp_r) begin
                errors++; $display("FAIL masked_trial %0d lat=%0d got %h want %h", t, lat, s0_out ^ s1_out ^ s2_out, exp_r);
            end
            if (t == 0) begin
                checks++;
                if (s0_out === um0 || s1_out === um1 || s2_out === um2) begin
                    errors++; $display("FAIL masked_shares_differ got a share equal to the unmasked run");
                end
            end
        end
    endtask

    task automatic test_pb();
        int lat; logic [319:0] st, exp_r;
        logic [7:0] pb_rc [6];
        pb_rc = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        st = rand320();
        exp_r = ascon_ref(st, 6);
        launch(st, '0, '0, 1'b1);
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (done) begin lat = n; break; end
            if ((n % 2) == 0) begin
                checks++;
                if (round_idx !== 4'(6 + n / 2) || dut.rc_w !== pb_rc[n / 2]) begin
                    errors++; $display("FAIL pb_round n=%0d idx=%0d rc=%h want idx=%0d rc=%h", n, round_idx, dut.rc_w, 6 + n / 2, pb_rc[n / 2]);
                end
            end
        end
        checks++; if (lat !== 12) begin errors++; $display("FAIL pb_latency got %0d want 12", lat); end
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== exp_r) begin errors++; $display("FAIL pb_result got %h want %h", s0_out ^ s1_out ^ s2_out, exp_r); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic [319:0] st, m1, exp_r;
        st = rand320(); m1 = rand320();
        exp_r = ascon_ref(st, 12);
        launch(st ^ m1, m1, '0, 1'b0);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 3 || n == 10) begin
                start = 1'b1; sel_pb = 1'b1; s0_in = rand320(); s1_in = rand320(); s2_in = rand320();
            end else begin
                start = 1'b0;
            end
            if (done) begin lat = n; break; end
        end
        start = 1'b0;
        checks++; if (lat !== 24) begin errors++; $display("FAIL ignore_latency got %0d want 24", lat); end
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== exp_r) begin errors++; $display("FAIL ignore_result got %h want %h", s0_out ^ s1_out ^ s2_out, exp_r); end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; logic [319:0] st1, st2, m1, m2;
        st1 = rand320(); st2 = rand320(); m1 = rand320(); m2 = rand320();
        launch(st1, '0, '0, 1'b0);
        wait_done(60, lat, bok);
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== ascon_ref(st1, 12)) begin errors++; $display("FAIL b2b_first got %h want %h", s0_out ^ s1_out ^ s2_out, ascon_ref(st1, 12)); end
        launch(st2 ^ m1 ^ m2, m1, m2, 1'b0);
        checks++; if (busy !== 1'b1 || s1_out !== m1 || s2_out !== m2) begin errors++; $display("FAIL b2b_load busy=%b s1=%h want %h", busy, s1_out, m1); end
        wait_done(60, lat, bok);
        checks++; if (lat !== 24 || !bok) begin errors++; $display("FAIL b2b_latency got %0d busy_ok=%b want 24 1", lat, bok); end
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== ascon_ref(st2, 12)) begin errors++; $display("FAIL b2b_second got %h want %h", s0_out ^ s1_out ^ s2_out, ascon_ref(st2, 12)); end
    endtask

    task automatic test_reset_midflight();
        int lat; bit bok; logic [319:0] st, m1;
        st = rand320(); m1 = rand320();
        launch(st, '0, '0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (round_idx !== 4'd4 || busy !== 1'b1) begin errors++; $display("FAIL mid_round idx=%0d busy=%b want 4 1", round_idx, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({s0_out, s1_out, s2_out} !== 960'd0) begin errors++; $display("FAIL mid_reset_shares got nonzero want 0"); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0) begin errors++; $display("FAIL mid_reset_flags busy=%b done=%b idx=%0d want 0 0 0", busy, done, round_idx); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        launch(st ^ m1, '0, m1, 1'b0);
        wait_done(60, lat, bok);
        checks++; if (lat !== 24 || (s0_out ^ s1_out ^ s2_out) !== ascon_ref(st, 12)) begin errors++; $display("FAIL post_reset_result lat=%0d got %h want %h", lat, s0_out ^ s1_out ^ s2_out, ascon_ref(st, 12)); end
    endtask

    task automatic test_zero();
        int lat; bit bok; logic [319:0] zero_s;
        zero_s = '0;
        launch(zero_s, zero_s, zero_s, 1'b0);
        wait_done(60, lat, bok);
        checks++; if ((s0_out ^ s1_out ^ s2_out) !== ascon_ref(zero_s, 12)) begin errors++; $display("FAIL zero_result got %h want %h", s0_out ^ s1_out ^ s2_out, ascon_ref(zero_s, 12)); end
    endtask

    initial begin
        test_reset();
        test_pa_unmasked();
        test_masked();
        test_pb();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midflight();
        test_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
